// File: rtl/ticket_request_dispatcher.sv
// Ticket request dispatcher: queues customer requests in a small FIFO and issues them
// to the ticket seller one at a time, reporting each result and keeping saturating tallies.
module ticket_request_dispatcher #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    input  logic [1:0]    req_cat,
    output logic          req_ready,
    input  logic          flush,
    output logic          purchase_vip,
    output logic          purchase_regular,
    output logic          purchase_student,
    output logic          purchase_senior,
    input  logic          purchase_success,
    input  logic          purchase_failed,
    output logic          done,
    output logic          done_ok,
    output logic [1:0]    done_cat,
    output logic [7:0]    served_count,
    output logic [7:0]    rejected_count,
    output logic [AW:0]   fifo_count,
    output logic          busy,
    output logic [1:0]    state_dbg
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_valid may be held across cycles, req_ready depends only on FIFO occupancy.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [1:0]      mem_q [DEPTH];
    logic [1:0]      mem_d [DEPTH];
    logic [1:0]      cur_cat_q, cur_cat_d;
    logic [3:0]      purch_q, purch_d;
    logic            done_q, done_d;
    logic            done_ok_q, done_ok_d;
    logic [1:0]      done_cat_q, done_cat_d;
    logic [7:0]      served_q, served_d;
    logic [7:0]      rejected_q, rejected_d;
    logic            busy_q, busy_d;
    logic            push, pop;
    logic            unused_failed;

    // Only the success flag decides the outcome; failed and "neither" both count as rejected.
    assign unused_failed = purchase_failed;

    assign req_ready = (count_q != FULL_CNT);
    assign push      = req_valid && req_ready && !flush;
    assign pop       = (state_q == S_IDLE) && (count_q != '0) && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = req_cat;
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push && !pop)      count_d = count_q + CNT_ONE;
            else if (pop && !push) count_d = count_q - CNT_ONE;
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_cat_d  = cur_cat_q;
        purch_d    = 4'b0000;
        done_d     = 1'b0;
        done_ok_d  = done_ok_q;
        done_cat_d = done_cat_q;
        served_d   = served_q;
        rejected_d = rejected_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    cur_cat_d = mem_q[rd_ptr_q];
                    // Registered pulse: set here so it is high exactly while in ISSUE.
                    purch_d   = 4'b0001 << mem_q[rd_ptr_q];
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                done_d     = 1'b1;
                done_cat_d = cur_cat_q;
                done_ok_d  = purchase_success;
                if (purchase_success) begin
                    if (served_q != 8'hFF) served_d = served_q + 8'd1;
                end else begin
                    if (rejected_q != 8'hFF) rejected_d = rejected_q + 8'd1;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 2'd0;
            cur_cat_q  <= 2'd0;
            purch_q    <= 4'b0000;
            done_q     <= 1'b0;
            done_ok_q  <= 1'b0;
            done_cat_q <= 2'd0;
            served_q   <= 8'd0;
            rejected_q <= 8'd0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            mem_q      <= mem_d;
            cur_cat_q  <= cur_cat_d;
            purch_q    <= purch_d;
            done_q     <= done_d;
            done_ok_q  <= done_ok_d;
            done_cat_q <= done_cat_d;
            served_q   <= served_d;
            rejected_q <= rejected_d;
            busy_q     <= busy_d;
        end
    end

    assign purchase_vip     = purch_q[0];
    assign purchase_regular = purch_q[1];
    assign purchase_student = purch_q[2];
    assign purchase_senior  = purch_q[3];
    assign done             = done_q;
    assign done_ok          = done_ok_q;
    assign done_cat         = done_cat_q;
    assign served_count     = served_q;
    assign rejected_count   = rejected_q;
    assign fifo_count       = count_q;
    assign busy             = busy_q;
    assign state_dbg        = state_q;

endmodule

// File: tb/tb_ticket_request_dispatcher.sv
// Directed bench for ticket_request_dispatcher: behavioural seller with per-category stock,
// scoreboard queue of expected {done_ok, done_cat} results, and a single summary line.
module tb_ticket_request_dispatcher;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_cat = 2'd0;
    logic       flush = 1'b0;
    logic       purchase_success;
    logic       purchase_failed;
    logic       req_ready;
    logic       purchase_vip, purchase_regular, purchase_student, purchase_senior;
    logic       done, done_ok;
    logic [1:0] done_cat;
    logic [7:0] served_count, rejected_count;
    logic [2:0] fifo_count;
    logic       busy;
    logic [1:0] state_dbg;
    logic [3:0] purch;

    int n_compared = 0;
    int n_mismatch = 0;
    logic [2:0] exp_q[$];
    logic [2:0] exp_e;
    int pulses_seen = 0;
    int full_seen = 0;
    logic prev_any = 1'b0;

    logic seller_rst_n = 1'b1;
    logic seller_mute = 1'b0;
    int   lim [4];
    int   sold [4];

    ticket_request_dispatcher #(.DEPTH(4), .AW(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_cat(req_cat), .req_ready(req_ready),
        .flush(flush),
        .purchase_vip(purchase_vip), .purchase_regular(purchase_regular),
        .purchase_student(purchase_student), .purchase_senior(purchase_senior),
        .purchase_success(purchase_success), .purchase_failed(purchase_failed),
        .done(done), .done_ok(done_ok), .done_cat(done_cat),
        .served_count(served_count), .rejected_count(rejected_count),
        .fifo_count(fifo_count), .busy(busy), .state_dbg(state_dbg)
    );

    assign purch = {purchase_senior, purchase_student, purchase_regular, purchase_vip};

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatch++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // seller model: sticky flags updated on the edge that ends a purchase pulse
    always @(posedge clk or negedge seller_rst_n) begin : seller
        int c;
        if (!seller_rst_n) begin
            purchase_success <= 1'b0;
            purchase_failed  <= 1'b0;
            for (int i = 0; i < 4; i++) sold[i] <= 0;
        end else if (!seller_mute && purch != 4'b0000) begin
            c = purch[0] ? 0 : purch[1] ? 1 : purch[2] ? 2 : 3;
            if (sold[c] < lim[c]) begin
                purchase_success <= 1'b1;
                purchase_failed  <= 1'b0;
                sold[c] <= sold[c] + 1;
            end else begin
                purchase_success <= 1'b0;
                purchase_failed  <= 1'b1;
            end
        end
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        if (reset) begin
            if (purch != 4'b0000) begin
                pulses_seen++;
                check("p_onehot", $countones(purch), 1);
                check("p_gap", prev_any, 0);
            end
            if (fifo_count == 3'd4) begin
                full_seen++;
                check("ready_full", req_ready, 0);
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("sb_extra_done", 1, 0);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("sb_ok", done_ok, exp_e[2]);
                    check("sb_cat", done_cat, exp_e[1:0]);
                end
            end
        end
        prev_any = (purch != 4'b0000);
    end

    // driver tasks (called at a negedge)
    task automatic seller_restock(input int l0, input int l1, input int l2, input int l3);
        lim[0] = l0; lim[1] = l1; lim[2] = l2; lim[3] = l3;
        seller_rst_n = 1'b0;
        #1;
        seller_rst_n = 1'b1;
    endtask

    task automatic push(input logic [1:0] cat);
        int t = 0;
        req_valid = 1'b1;
        req_cat = cat;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("push_timeout", 0, 1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [1:0] cat, input logic ok);
        exp_q.push_back({ok, cat});
        push(cat);
    endtask

    task automatic wait_drain(input string tag);
        int t = 0;
        while ((fifo_count != 0 || busy || done || exp_q.size() != 0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        check(tag, (t < 300), 1);
    endtask

    initial begin
        int p0;
        int f0;
        logic [1:0] wrap_cats [7];
        wrap_cats = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd0};

        seller_restock(5, 5, 5, 5);
        repeat (2) @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_purch", purch, 0);
        check("rst_done", done, 0);
        check("rst_done_ok", done_ok, 0);
        check("rst_done_cat", done_cat, 0);
        check("rst_served", served_count, 0);
        check("rst_rejected", rejected_count, 0);
        check("rst_fifo", fifo_count, 0);
        check("rst_busy", busy, 0);
        check("rst_state", state_dbg, 0);
        reset = 1'b1;
        @(negedge clk);

        // single VIP request with stock
        exp_q.push_back({1'b1, 2'd0});
        push(2'd0);
        check("vip_fifo1", fifo_count, 1);
        check("vip_p_early", purch, 0);
        @(negedge clk);
        check("vip_p_issue", purch, 4'b0001);
        check("vip_busy_issue", busy, 1);
        check("vip_fifo0", fifo_count, 0);
        @(negedge clk);
        check("vip_p_wait", purch, 0);
        check("vip_done_early", done, 0);
        @(negedge clk);
        check("vip_done", done, 1);
        check("vip_done_ok", done_ok, 1);
        check("vip_done_cat", done_cat, 0);
        check("vip_served", served_count, 1);
        check("vip_busy_idle", busy, 0);
        @(negedge clk);
        check("vip_done_pulse", done, 0);

        // asynchronous reset in the middle of ISSUE
        exp_q.push_back({1'b1, 2'd0});
        push(2'd0);
        @(negedge clk);
        check("mid_p_issue", purch, 4'b0001);
        #2;
        reset = 1'b0;
        #1;
        check("mid_p_drop", purch, 0);
        check("mid_busy", busy, 0);
        check("mid_served", served_count, 0);
        check("mid_ready", req_ready, 1);
        check("mid_fifo", fifo_count, 0);
        exp_q.delete();
        @(negedge clk);
        check("mid_still_low", purch, 0);
        reset = 1'b1;
        @(negedge clk);

        // sold-out senior: seller holds 3
        seller_restock(0, 0, 0, 3);
        push_exp(2'd3, 1'b1);
        push_exp(2'd3, 1'b1);
        push_exp(2'd3, 1'b1);
        push_exp(2'd3, 1'b0);
        wait_drain("senior_drain");
        check("senior_served", served_count, 3);
        check("senior_rejected", rejected_count, 1);

        // seller raising neither flag counts as rejected
        seller_mute = 1'b1;
        seller_restock(9, 9, 9, 9);
        push_exp(2'd1, 1'b0);
        wait_drain("mute_drain");
        check("mute_rejected", rejected_count, 2);
        check("mute_served", served_count, 3);
        seller_mute = 1'b0;

        // FIFO fill, refused push while full, pointer wrap
        seller_restock(9, 9, 9, 9);
        f0 = full_seen;
        for (int i = 0; i < 7; i++) push_exp(wrap_cats[i], 1'b1);
        wait_drain("wrap_drain");
        check("wrap_full_seen", (full_seen > f0), 1);
        check("wrap_served", served_count, 10);

        // flush during ISSUE of the first; same-cycle push is discarded
        seller_restock(9, 9, 9, 9);
        exp_q.push_back({1'b1, 2'd2});
        req_valid = 1'b1;
        req_cat = 2'd2;
        @(negedge clk);
        req_cat = 2'd1;
        @(negedge clk);
        check("fl_issue", purch, 4'b0100);
        check("fl_fifo_pre", fifo_count, 1);
        req_cat = 2'd0;
        flush = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        flush = 1'b0;
        check("fl_fifo0", fifo_count, 0);
        check("fl_busy", busy, 1);
        p0 = pulses_seen;
        repeat (12) @(negedge clk);
        check("fl_no_pulse", pulses_seen, p0);
        check("fl_first_done", exp_q.size(), 0);
        check("fl_served", served_count, 11);

        // saturation of served_count
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        seller_restock(300, 0, 0, 0);
        @(negedge clk);
        for (int i = 0; i < 260; i++) push_exp(2'd0, 1'b1);
        wait_drain("sat_drain");
        check("sat_served", served_count, 255);
        check("sat_rejected", rejected_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule

// File: doc/ticket_request_dispatcher.md
# ticket_request_dispatcher

Upstream stage of the digital ticketing system: buffers customer ticket requests in a small FIFO and feeds the ticket seller one purchase at a time. Each purchase is a single one-hot, single-cycle pulse on the seller's purchase_* inputs. The block samples the seller's purchase_success / purchase_failed result, reports it per request, and keeps saturating served/rejected tallies. Serialising requests guarantees the seller never sees simultaneous category requests.

## Interface
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- AW, 2: log2(DEPTH).
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- req_valid  in  1  customer request present.
- req_cat  in  2  category: 0 VIP, 1 regular, 2 student, 3 senior.
- req_ready  out  1  FIFO can accept; a transfer occurs when req_valid && req_ready.
- flush  in  1  synchronous; discards all queued (not in-flight) requests.
- purchase_vip / purchase_regular / purchase_student / purchase_senior  out  1 each  one-hot purchase pulse to seller.
- purchase_success  in  1  seller result flag.
- purchase_failed  in  1  seller result flag.
- done  out  1  one-cycle pulse: result of one request available.
- done_ok  out  1  valid with done; 1 = ticket issued, 0 = sold out.
- done_cat  out  2  category of the completed request; valid with done.
- served_count  out  8  successful purchases, saturates at 255.
- rejected_count  out  8  failed purchases, saturates at 255.
- fifo_count  out  AW+1  queued entries, 0..DEPTH.
- busy  out  1  FSM not in IDLE.

## Operation
- FIFO
  - Circular buffer, AW-bit read/write pointers with natural wrap; occupancy counter of AW+1 bits.
  - req_ready = (fifo_count != DEPTH). A push is refused when full even if a pop occurs the same cycle.
  - Push and pop in the same cycle (not full): count unchanged, both pointers advance.
  - flush resets pointers and count to 0, takes priority over a same-cycle push, and does not affect the in-flight request.
- FSM (states: IDLE, ISSUE, WAIT)
  - IDLE: if fifo_count != 0 and no flush, pop the head into cur_cat and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: drive exactly one purchase_* output high, selected by cur_cat, for this cycle only. Go to WAIT.
  - WAIT: the seller updated its flags at the edge ending ISSUE. Sample them:
    - purchase_success = 1: done_ok = 1, increment served_count.
    - purchase_success = 0 (failed, or neither flag set): done_ok = 0, increment rejected_count.
    - Pulse done for one cycle with done_cat = cur_cat, then go to IDLE.
  - The seller's flags are sticky, so they are sampled only in WAIT and ignored in every other state.
- All outputs are registered: purchase_*, done, done_ok, done_cat, counters and busy.
- Counters saturate: no increment once at 255.

## Timing
- Reset values: req_ready 1, all purchase_* 0, done 0, done_ok 0, done_cat 0, served_count 0, rejected_count 0, fifo_count 0, busy 0. FSM resets to IDLE; pointers reset to 0.
- Latency:
  - A push at edge N into an empty FIFO with the FSM idle: pop at edge N+1, purchase_* high in cycle N+1..N+2, done in cycle N+3..N+4.
  - Three cycles per request; throughput is one request per 3 clocks.
- fifo_count reflects a push or pop on the cycle after the edge.
- busy is high in ISSUE and WAIT.
- Reset asserted mid-operation: a purchase_* pulse or done drops asynchronously, queued and in-flight requests are lost, and counters clear.
- purchase_* outputs are never high on two consecutive cycles and never more than one at a time.

## Test plan
- Reset/idle: assert reset low mid-ISSUE -> purchase_vip drops at once; all outputs take their reset values; req_ready = 1.
- Single VIP request, seller with stock: one push req_cat = 0 -> purchase_vip high exactly 1 cycle, 2 cycles after push; done = 1, done_ok = 1, done_cat = 0 two cycles later; served_count = 1.
- Sold-out senior: issue 4 senior requests against a seller holding 3 -> first three give done_ok = 1; the fourth gives done_ok = 0; served_count = 3, rejected_count = 1.
- FIFO full/wrap:
  - With DEPTH = 4, push 6 back-to-back requests while the FSM drains -> req_ready deasserts when fifo_count = 4.
  - No request is lost or duplicated; done_cat sequence matches push order across pointer wrap.
- Flush: queue 3 requests, assert flush during ISSUE of the first -> the first completes with done; fifo_count = 0 next cycle; no further purchase_* pulses.
- Saturation: drive 260 successful purchases (seller replenished via its own reset) -> served_count holds at 255.
